// File: rtl/execution_stage.sv
// Single-cycle execute stage: 16-bit unsigned ALU with registered result and
// registered pass-through of the register-file and memory control fields.
module execution_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [15:0] operand1,
    input  logic [15:0] operand2,
    input  logic        write_enable,
    input  logic        store_enable,
    input  logic [3:0]  reg_addr,
    input  logic [3:0]  mem_addr,
    input  logic        load_enable,
    output logic [15:0] result,
    output logic [3:0]  reg_addr_out,
    output logic        write_enable_out,
    output logic [3:0]  mem_addr_out,
    output logic        store_enable_out,
    output logic        load_enable_out
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_SHL   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;

    function automatic logic [15:0] alu_op(
        input logic [3:0]  op,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] r;
        r = 16'h0000;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_LOAD:  r = a;
            OP_STORE: r = a;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOT:   r = ~a;
            OP_SHL:   r = a << b[3:0];
            OP_SHR:   r = a >> b[3:0];
            default:  r = 16'h0000;
        endcase
        return r;
    endfunction

    logic [15:0] result_p1_d,           result_p1_q;
    logic [3:0]  reg_addr_p1_d,         reg_addr_p1_q;
    logic        write_enable_p1_d,     write_enable_p1_q;
    logic [3:0]  mem_addr_p1_d,         mem_addr_p1_q;
    logic        store_enable_p1_d,     store_enable_p1_q;
    logic        load_enable_p1_d,      load_enable_p1_q;

    always_comb begin
        result_p1_d       = alu_op(opcode, operand1, operand2);
        reg_addr_p1_d     = reg_addr;
        write_enable_p1_d = write_enable;
        mem_addr_p1_d     = mem_addr;
        store_enable_p1_d = store_enable;
        load_enable_p1_d  = load_enable;
    end

    // Stage p1: everything, including the ALU result, is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1_q       <= 16'h0000;
            reg_addr_p1_q     <= 4'h0;
            write_enable_p1_q <= 1'b0;
            mem_addr_p1_q     <= 4'h0;
            store_enable_p1_q <= 1'b0;
            load_enable_p1_q  <= 1'b0;
        end else begin
            result_p1_q       <= result_p1_d;
            reg_addr_p1_q     <= reg_addr_p1_d;
            write_enable_p1_q <= write_enable_p1_d;
            mem_addr_p1_q     <= mem_addr_p1_d;
            store_enable_p1_q <= store_enable_p1_d;
            load_enable_p1_q  <= load_enable_p1_d;
        end
    end

    assign result           = result_p1_q;
    assign reg_addr_out     = reg_addr_p1_q;
    assign write_enable_out = write_enable_p1_q;
    assign mem_addr_out     = mem_addr_p1_q;
    assign store_enable_out = store_enable_p1_q;
    assign load_enable_out  = load_enable_p1_q;

endmodule

// File: tb/tb_execution_stage.sv
// Bench for execution_stage: directed vectors plus random operations checked
// against an arithmetic reference model.
module tb_execution_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic [15:0] operand1, operand2;
    logic        write_enable, store_enable, load_enable;
    logic [3:0]  reg_addr, mem_addr;
    logic [15:0] result;
    logic [3:0]  reg_addr_out, mem_addr_out;
    logic        write_enable_out, store_enable_out, load_enable_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execution_stage dut (
        .clk(clk), .rst(rst), .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .write_enable(write_enable), .store_enable(store_enable), .reg_addr(reg_addr),
        .mem_addr(mem_addr), .load_enable(load_enable), .result(result),
        .reg_addr_out(reg_addr_out), .write_enable_out(write_enable_out),
        .mem_addr_out(mem_addr_out), .store_enable_out(store_enable_out),
        .load_enable_out(load_enable_out)
    );

    // Reference: plain unsigned integer arithmetic reduced modulo 2^16.
    function automatic logic [15:0] model(input int op, input int unsigned a, input int unsigned b);
        int unsigned s;
        s = b % 16;
        case (op)
            1:       return 16'((a + b) % 65536);
            2:       return 16'((a + 65536 - b) % 65536);
            3, 4:    return 16'(a);
            5:       return 16'(a & b);
            6:       return 16'(a | b);
            7:       return 16'(a ^ b);
            8:       return 16'(65535 - a);
            9:       return 16'((a * (32'd1 << s)) % 65536);
            10:      return 16'(a / (32'd1 << s));
            default: return 16'd0;
        endcase
    endfunction

    task automatic drive(input logic r, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic we, input logic se,
                         input logic [3:0] ra, input logic [3:0] ma, input logic le);
        rst = r; opcode = op; operand1 = a; operand2 = b;
        write_enable = we; store_enable = se; reg_addr = ra; mem_addr = ma; load_enable = le;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 4'b0001, 16'h1234, 16'h1111, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        checks++;
        if ({result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state: got result=%h ra=%h we=%b ma=%h se=%b le=%b, expected all zero",
                     result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out);
        end
    endtask

    task automatic test_arith;
        drive(1'b0, 4'b0001, 16'd5, 16'd3, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
        checks++;
        if ({result, reg_addr_out, write_enable_out} !== {16'd8, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL add_5_3: got result=%0d ra=%0d we=%b, expected 8 1 1", result, reg_addr_out, write_enable_out);
        end
        drive(1'b0, 4'b0010, 16'd10, 16'd4, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0);
        checks++;
        if ({result, reg_addr_out} !== {16'd6, 4'd2}) begin
            errors++;
            $display("FAIL sub_10_4: got result=%0d ra=%0d, expected 6 2", result, reg_addr_out);
        end
        drive(1'b0, 4'b0010, 16'd0, 16'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'hFFFF) begin
            errors++;
            $display("FAIL sub_wrap: got %h expected ffff", result);
        end
        drive(1'b0, 4'b0001, 16'hFFFF, 16'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL add_wrap: got %h expected 0000", result);
        end
    endtask

    task automatic test_load_store;
        drive(1'b0, 4'b0011, 16'd25, 16'hABCD, 1'b1, 1'b0, 4'd3, 4'd0, 1'b1);
        checks++;
        if ({result, reg_addr_out, write_enable_out, load_enable_out} !== {16'd25, 4'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL load: got result=%0d ra=%0d we=%b le=%b, expected 25 3 1 1",
                     result, reg_addr_out, write_enable_out, load_enable_out);
        end
        drive(1'b0, 4'b0100, 16'd15, 16'h5555, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0);
        checks++;
        if ({result, mem_addr_out, store_enable_out} !== {16'd15, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL store: got result=%0d ma=%0d se=%b, expected 15 1 1", result, mem_addr_out, store_enable_out);
        end
    endtask

    task automatic test_logic_invalid;
        drive(1'b0, 4'b0101, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'h00F0) begin errors++; $display("FAIL and: got %h expected 00f0", result); end
        drive(1'b0, 4'b0110, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'h0FF0) begin errors++; $display("FAIL or: got %h expected 0ff0", result); end
        drive(1'b0, 4'b0111, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'h0F00) begin errors++; $display("FAIL xor: got %h expected 0f00", result); end
        drive(1'b0, 4'b1001, 16'h0001, 16'd15, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (result !== 16'h8000) begin errors++; $display("FAIL shl_15: got %h expected 8000", result); end
        drive(1'b0, 4'b1111, 16'h1234, 16'h4321, 1'b1, 1'b1, 4'd9, 4'd6, 1'b1);
        checks++;
        if ({result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out}
            !== {16'h0000, 4'd9, 1'b1, 4'd6, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL invalid_op: got result=%h ra=%h we=%b ma=%h se=%b le=%b, expected 0000 9 1 6 1 1",
                     result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b, exp_r;
            logic [3:0]  ra, ma;
            logic        we, se, le;
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ra = 4'($urandom); ma = 4'($urandom);
            we = 1'($urandom); se = 1'($urandom); le = 1'($urandom);
            exp_r = model(int'(op), int'(a), int'(b));
            drive(1'b0, op, a, b, we, se, ra, ma, le);
            checks++;
            if ({result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out}
                !== {exp_r, ra, we, ma, se, le}) begin
                errors++;
                $display("FAIL random_op%0d: op=%b a=%h b=%h got result=%h ctl=%h_%b_%h_%b_%b expected result=%h ctl=%h_%b_%h_%b_%b",
                         i, op, a, b, result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out,
                         load_enable_out, exp_r, ra, we, ma, se, le);
            end
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b0, 4'b0001, 16'd100, 16'd23, 1'b1, 1'b0, 4'd7, 4'd2, 1'b0);
        checks++;
        if ({result, reg_addr_out} !== {16'd123, 4'd7}) begin
            errors++;
            $display("FAIL pre_reset_add: got result=%0d ra=%0d expected 123 7", result, reg_addr_out);
        end
        drive(1'b1, 4'b0001, 16'd40, 16'd2, 1'b1, 1'b1, 4'd5, 4'd5, 1'b1);
        checks++;
        if ({result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out} !== 29'd0) begin
            errors++;
            $display("FAIL midstream_reset: got result=%h ra=%h we=%b ma=%h se=%b le=%b, expected all zero",
                     result, reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out);
        end
        drive(1'b0, 4'b0001, 16'd40, 16'd2, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0);
        checks++;
        if ({result, reg_addr_out, write_enable_out} !== {16'd42, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_add: got result=%0d ra=%0d we=%b expected 42 5 1",
                     result, reg_addr_out, write_enable_out);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_load_store();
        test_logic_invalid();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execution_stage.md
EXECUTION_STAGE -- requirements
Module: execution_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  operation select.
REQ-005 operand1  input  16  first ALU operand; also the pass-through value for LOAD/STORE.
REQ-006 operand2  input  16  second ALU operand; shift amount source (bits [3:0]).
REQ-007 write_enable  input  1  register-file write request from decode.
REQ-008 store_enable  input  1  memory store request from decode.
REQ-009 reg_addr  input  4  destination register address.
REQ-010 mem_addr  input  4  memory address.
REQ-011 load_enable  input  1  memory load request from decode.
REQ-012 result  output  16  registered ALU result.
REQ-013 reg_addr_out  output  4  registered copy of reg_addr.
REQ-014 write_enable_out  output  1  registered copy of write_enable.
REQ-015 mem_addr_out  output  4  registered copy of mem_addr.
REQ-016 store_enable_out  output  1  registered copy of store_enable.
REQ-017 load_enable_out  output  1  registered copy of load_enable.

Function
REQ-018 All outputs SHALL be registers updated only on the rising edge of clk; latency from input to output is exactly one cycle; no combinational input-to-output path.
REQ-019 result SHALL be computed from the opcode and operands sampled at the same edge:
- 0001 ADD: operand1 + operand2, modulo 2^16 (carry discarded).
- 0010 SUB: operand1 - operand2, modulo 2^16 (borrow wraps, e.g. 3-5 = 0xFFFE).
- 0011 LOAD: operand1 unchanged.
- 0100 STORE: operand1 unchanged (data to be written to memory).
- 0101 AND: operand1 & operand2.
- 0110 OR: operand1 | operand2.
- 0111 XOR: operand1 ^ operand2.
- 1000 NOT: ~operand1.
- 1001 SHL: operand1 logically shifted left by operand2[3:0], zero fill.
- 1010 SHR: operand1 logically shifted right by operand2[3:0], zero fill.
- 0000 and 1011-1111: result = 0x0000.
REQ-020 reg_addr_out, write_enable_out, mem_addr_out, store_enable_out, load_enable_out SHALL be one-cycle delayed copies of their inputs for every opcode, including invalid ones; the block does not qualify control signals by opcode.
REQ-021 Operands SHALL be treated as unsigned; no flags or exceptions are produced.
REQ-022 A new operation SHALL be accepted every cycle (fully pipelined, no stall or handshake).

Reset
REQ-023 When rst is high at a rising edge, all outputs SHALL be cleared to 0 on that edge, overriding any operation presented in the same cycle.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight operation; the first operation after rst deasserts appears one cycle after it is sampled.

Verification
REQ-025 ADD: opcode=0001, operand1=5, operand2=3, write_enable=1, reg_addr=1 -> next cycle result=8, reg_addr_out=1, write_enable_out=1.
REQ-026 SUB: opcode=0010, operand1=10, operand2=4, reg_addr=2 -> result=6, reg_addr_out=2; also 0-1 -> result=0xFFFF; ADD 0xFFFF+1 -> 0x0000.
REQ-027 LOAD: opcode=0011, operand1=25, reg_addr=3, write_enable=1 -> result=25, reg_addr_out=3, write_enable_out=1.
REQ-028 STORE: opcode=0100, operand1=15, store_enable=1, mem_addr=1 -> result=15, mem_addr_out=1, store_enable_out=1.
REQ-029 Invalid opcode 1111 with other inputs held -> result=0, control outputs still equal the held inputs; logic ops: 0x00F0 AND/OR/XOR 0x0FF0 -> 0x00F0/0x0FF0/0x0F00; SHL 0x0001 by 15 -> 0x8000.
REQ-030 Reset: assert rst during a valid ADD -> all outputs 0 the following cycle; deassert -> next operation output appears after one cycle.
